// File: rtl/vehicle_sensor.sv
// Country-road vehicle detector: synchronizes and debounces the loop, latches arrivals,
// and raises a registered call to the signal controller once highway min-green has elapsed.
module vehicle_sensor #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_GREEN  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       loop_raw,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  output logic       x,
  output logic       req_pending,
  output logic [7:0] car_count,
  output logic       fault
);

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] GREEN = 2'b10;
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] MG_MAX   = 8'(MIN_GREEN);

  typedef enum logic [1:0] {IDLE, WAIT_MG, CALL, SERVE} state_t;

  state_t     state, state_next;
  logic       loop_s1, loop_s;
  logic       loop_db, db_prev;
  logic [7:0] deb_cnt;
  logic [7:0] mg_cnt;
  logic       arrival, fault_now, fault_any, serve_edge;

  assign arrival    = loop_db & ~db_prev;
  assign fault_now  = (hwy == 2'b11) || (cntry == 2'b11) || ((hwy != RED) && (cntry != RED));
  assign fault_any  = fault | fault_now;
  assign serve_edge = (state == CALL) && (state_next == SERVE);

  // Debounce: loop_db flips only after DEB_CYCLES consecutive disagreeing edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_s1 <= 1'b0;
      loop_s  <= 1'b0;
      loop_db <= 1'b0;
      db_prev <= 1'b0;
      deb_cnt <= 8'd0;
    end else begin
      loop_s1 <= loop_raw;
      loop_s  <= loop_s1;
      db_prev <= loop_db;
      if (loop_s != loop_db) begin
        if (deb_cnt == DEB_LAST) begin
          loop_db <= ~loop_db;
          deb_cnt <= 8'd0;
        end else begin
          deb_cnt <= deb_cnt + 8'd1;
        end
      end else begin
        deb_cnt <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mg_cnt <= 8'd0;
    end else if (hwy == GREEN) begin
      if (mg_cnt != MG_MAX) mg_cnt <= mg_cnt + 8'd1;
    end else begin
      mg_cnt <= 8'd0;
    end
  end

  // Arrival set has priority over the serve-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pending <= 1'b0;
      car_count   <= 8'd0;
      fault       <= 1'b0;
    end else begin
      fault <= fault_any;
      if (arrival) req_pending <= 1'b1;
      else if (serve_edge) req_pending <= 1'b0;
      if (arrival && (car_count != 8'hFF)) car_count <= car_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= 1'b0;
    end else begin
      state <= state_next;
      x     <= (state_next == CALL);
    end
  end

  // x is a level call: held from CALL entry until the controller shows country green.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_pending) state_next = WAIT_MG;
      WAIT_MG: if ((hwy == GREEN) && (mg_cnt == MG_MAX)) state_next = CALL;
      CALL:    if (cntry == GREEN) state_next = SERVE;
      SERVE:   if ((hwy == GREEN) && (cntry == RED)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (fault_any) state_next = IDLE;
  end

endmodule

// File: tb/tb_vehicle_sensor.sv
// Directed bench for vehicle_sensor: expected {x, req_pending, fault, car_count} words are
// queued as stimulus is applied and compared against the DUT after the clock edges.
module tb_vehicle_sensor;

  localparam logic [1:0] RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       loop_raw;
  logic [1:0] hwy, cntry;
  logic       x, req_pending, fault;
  logic [7:0] car_count;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] status;

  assign status = {x, req_pending, fault, car_count};

  vehicle_sensor #(.DEB_CYCLES(4), .MIN_GREEN(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .loop_raw    (loop_raw),
    .hwy         (hwy),
    .cntry       (cntry),
    .x           (x),
    .req_pending (req_pending),
    .car_count   (car_count),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic xe, input logic re, input logic fe, input logic [7:0] ce);
    exp_q.push_back({xe, re, fe, ce});
  endtask

  task automatic pop_cmp(input string tag);
    logic [10:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(status), 32'(e));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    push_exp(0, 0, 0, 8'd0);
    pop_cmp("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic serve_cycle(input logic [7:0] cnt);
    hwy = YELLOW; push_exp(1, 1, 0, cnt); tick(); pop_cmp("call_hold_yellow");
    hwy = RED;    push_exp(1, 1, 0, cnt); tick(); pop_cmp("call_hold_red");
    cntry = GREEN; push_exp(0, 0, 0, cnt); tick(); pop_cmp("serve_edge");
    cntry = RED; tick();
    hwy = GREEN; push_exp(0, 0, 0, cnt); tick(); pop_cmp("serve_to_idle");
  endtask

  initial begin
    rst_n = 1'b0; loop_raw = 1'b0; hwy = GREEN; cntry = RED;
    do_reset();

    // Basic arrival with min-green already satisfied
    tick(20);
    loop_raw = 1'b1;
    tick(5);
    check("loop_db_edge5", 32'(dut.loop_db), 32'd0);
    push_exp(0, 0, 0, 8'd0); tick(); pop_cmp("edge6_status");
    check("loop_db_edge6", 32'(dut.loop_db), 32'd1);
    push_exp(0, 1, 0, 8'd1); tick(); pop_cmp("edge7_arrival");
    push_exp(0, 1, 0, 8'd1); tick(); pop_cmp("edge8_wait_mg");
    push_exp(1, 1, 0, 8'd1); tick(); pop_cmp("edge9_call");
    serve_cycle(8'd1);

    // Short green must not satisfy min-green
    loop_raw = 1'b0; hwy = RED;
    tick(10);
    loop_raw = 1'b1;
    push_exp(0, 1, 0, 8'd2); tick(7); pop_cmp("arrival2");
    tick();
    hwy = GREEN; tick(5);
    hwy = RED;
    push_exp(0, 1, 0, 8'd2); tick(); pop_cmp("short_green_no_call");
    hwy = GREEN;
    push_exp(0, 1, 0, 8'd2); tick(16); pop_cmp("mg_not_yet");
    push_exp(1, 1, 0, 8'd2); tick(); pop_cmp("mg_reached_call");
    serve_cycle(8'd2);

    // Glitch of 3 cycles is rejected
    loop_raw = 1'b0;
    do_reset();
    tick(3);
    loop_raw = 1'b1; tick(3);
    loop_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch_x", 32'(x), 32'd0);
      check("glitch_db", 32'(dut.loop_db), 32'd0);
    end
    push_exp(0, 0, 0, 8'd0); tick(); pop_cmp("glitch_status");

    // Illegal combination sets sticky fault; counting continues and saturates
    cntry = YELLOW;
    push_exp(0, 0, 1, 8'd0); tick(); pop_cmp("fault_set");
    cntry = RED;
    push_exp(0, 0, 1, 8'd0); tick(); pop_cmp("fault_sticky");
    for (int a = 0; a < 300; a++) begin
      loop_raw = 1'b1;
      push_exp(0, 1, 1, (a + 1 > 255) ? 8'd255 : 8'(a + 1));
      tick(8);
      loop_raw = 1'b0;
      tick(8);
      pop_cmp("fault_arrivals");
    end
    #2 rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 8'd0); pop_cmp("fault_reset_clear");
    check("reset_db", 32'(dut.loop_db), 32'd0);
    tick();
    rst_n = 1'b1;

    // Reset between edges while calling drops x at once
    tick(20);
    loop_raw = 1'b1;
    push_exp(1, 1, 0, 8'd1); tick(9); pop_cmp("pre_reset_call");
    #2 rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 8'd0); pop_cmp("async_reset_mid_call");
    loop_raw = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(2);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
